avmm_burst_writer: RTL

Write-DMA engine that drains a 512-bit show-ahead FIFO into DRAM over an Avalon-MM burst master. It sits directly downstream of the processing-element send FIFO and replaces single-beat FIFO-to-DRAM draining with bursts of up to MAX_BURST words. It writes a programmed number of words to consecutive 64-byte-aligned addresses, then reports completion to the CSR block.

---
 rtl/avmm_burst_writer.sv | 114 +++++++++++
 1 files changed

// File: rtl/avmm_burst_writer.sv
// Write-DMA engine: drains a show-ahead FIFO into memory as Avalon-MM write bursts
// of up to MAX_BURST words at consecutive 64-byte-aligned addresses.
module avmm_burst_writer #(
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 64,
  parameter int BURST_W = 3,
  parameter int USEDW_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [63:0]        word_count,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  input  logic               avm_waitrequest,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic [DATA_W-1:0]  avm_writedata,
  output logic               avm_write,
  output logic [63:0]        avm_byteenable,
  output logic               busy,
  output logic               done,
  output logic [63:0]        words_written
);

  localparam int MAX_BURST = 1 << (BURST_W - 1);

  typedef enum logic [1:0] {IDLE, ARM, BURST, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [63:0]        remaining;
  logic [BURST_W-1:0] beats;
  logic [BURST_W-1:0] len;
  logic               accept;

  always_comb begin
    len    = (remaining < 64'(MAX_BURST)) ? remaining[BURST_W-1:0] : BURST_W'(MAX_BURST);
    accept = avm_write & ~avm_waitrequest;
  end

  // NOTE: the pop is combinational so the FIFO advances on the same edge the slave
  // accepts the beat; a registered pop would present each word twice.
  assign fifo_rdreq     = accept;
  assign avm_writedata  = fifo_q;
  assign avm_byteenable = '1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      beats          <= '0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= BURST_W'(1);
      words_written  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr          <= {dst_addr[ADDR_W-1:6], 6'b0};
            remaining     <= word_count;
            words_written <= '0;
            if (word_count == 64'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ARM;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        // Hold off until the whole burst is resident so the write never starves mid-burst.
        ARM: begin
          if (fifo_usedw >= USEDW_W'(len)) begin
            avm_address    <= addr;
            avm_burstcount <= len;
            beats          <= len;
            avm_write      <= 1'b1;
            state          <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            words_written <= words_written + 64'd1;
            beats         <= beats - BURST_W'(1);
            if (beats == BURST_W'(1)) begin
              avm_write <= 1'b0;
              addr      <= addr + (ADDR_W'(avm_burstcount) << 6);
              remaining <= remaining - 64'(avm_burstcount);
              if (remaining == 64'(avm_burstcount)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ARM;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
